pong_match_ctl: RTL

PONG_MATCH_CTL -- requirements
Module: pong_match_ctl

---
 rtl/pong_match_ctl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pong_match_ctl.sv
// Match controller for a two-player Pong board: serve delay, miss detection,
// scoring, match-over hold and restart, all paced by the per-frame tick.
module pong_match_ctl #(
  parameter int GAME_WIDTH    = 40,
  parameter int PADDLE_HEIGHT = 6,
  parameter int SCORE_LIMIT   = 9,
  parameter int SCORE_WIDTH   = 4,
  parameter int COORD_WIDTH   = 6,
  parameter int SERVE_FRAMES  = 60,
  parameter int HOLD_FRAMES   = 180
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   Game_Start_i,
  input  logic                   Frame_Tick_i,
  input  logic [COORD_WIDTH-1:0] Ball_X_i,
  input  logic [COORD_WIDTH-1:0] Ball_Y_i,
  input  logic [COORD_WIDTH-1:0] Paddle_Y_P1_i,
  input  logic [COORD_WIDTH-1:0] Paddle_Y_P2_i,
  output logic                   Game_Active_o,
  output logic                   Ball_Reset_o,
  output logic                   Point_P1_o,
  output logic                   Point_P2_o,
  output logic                   Serve_Dir_o,
  output logic [SCORE_WIDTH-1:0] P1_Score_o,
  output logic [SCORE_WIDTH-1:0] P2_Score_o,
  output logic                   Match_Over_o,
  output logic                   Winner_o,
  output logic [2:0]             State_o
);

  localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);
  localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
  localparam logic [SERVE_W-1:0]     SERVE_LOAD = SERVE_W'(SERVE_FRAMES);
  localparam logic [HOLD_W-1:0]      HOLD_LOAD  = HOLD_W'(HOLD_FRAMES);
  localparam logic [SCORE_WIDTH-1:0] WIN_SCORE  = SCORE_WIDTH'(SCORE_LIMIT);
  localparam logic [COORD_WIDTH-1:0] RIGHT_X    = COORD_WIDTH'(GAME_WIDTH - 1);
  localparam logic [COORD_WIDTH:0]   PAD_SPAN   = (COORD_WIDTH + 1)'(PADDLE_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE      = 3'd1,
    RUNNING    = 3'd2,
    POINT      = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;

  state_t state, state_next;

  logic [SERVE_W-1:0] serve_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               scorer_p2;

  // Paddle span is evaluated one bit wider so a paddle near the bottom never wraps.
  logic [COORD_WIDTH:0] ball_y_ext, p1_top, p1_bot, p2_top, p2_bot;
  logic                 miss_p1, miss_p2, match_won;

  assign ball_y_ext = {1'b0, Ball_Y_i};
  assign p1_top     = {1'b0, Paddle_Y_P1_i};
  assign p2_top     = {1'b0, Paddle_Y_P2_i};
  assign p1_bot     = p1_top + PAD_SPAN;
  assign p2_bot     = p2_top + PAD_SPAN;

  assign miss_p1 = (Ball_X_i == '0) &&
                   ((ball_y_ext < p1_top) || (ball_y_ext > p1_bot));
  assign miss_p2 = (Ball_X_i == RIGHT_X) &&
                   ((ball_y_ext < p2_top) || (ball_y_ext > p2_bot));

  assign match_won = ((scorer_p2 ? P2_Score_o : P1_Score_o) == WIN_SCORE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (Game_Start_i) state_next = SERVE;
      SERVE:      if (Frame_Tick_i && (serve_cnt == SERVE_W'(1))) state_next = RUNNING;
      RUNNING:    if (miss_p1 || miss_p2) state_next = POINT;
      POINT:      state_next = match_won ? MATCH_OVER : SERVE;
      MATCH_OVER: if (hold_cnt == '0) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Registered scoring / counter datapath; score is bumped on entry to POINT
  // so the new value and the point pulse are visible together during POINT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      serve_cnt    <= '0;
      hold_cnt     <= '0;
      scorer_p2    <= 1'b0;
      Point_P1_o   <= 1'b0;
      Point_P2_o   <= 1'b0;
      Serve_Dir_o  <= 1'b0;
      P1_Score_o   <= '0;
      P2_Score_o   <= '0;
      Match_Over_o <= 1'b0;
      Winner_o     <= 1'b0;
    end else begin
      Point_P1_o <= 1'b0;
      Point_P2_o <= 1'b0;
      case (state)
        IDLE: begin
          if (Game_Start_i) begin
            P1_Score_o   <= '0;
            P2_Score_o   <= '0;
            Winner_o     <= 1'b0;
            Match_Over_o <= 1'b0;
            serve_cnt    <= SERVE_LOAD;
          end
        end
        SERVE: begin
          if (Frame_Tick_i && (serve_cnt != '0)) serve_cnt <= serve_cnt - SERVE_W'(1);
        end
        RUNNING: begin
          if (miss_p1) begin
            scorer_p2   <= 1'b1;
            P2_Score_o  <= P2_Score_o + SCORE_WIDTH'(1);
            Point_P2_o  <= 1'b1;
            Serve_Dir_o <= 1'b0;
          end else if (miss_p2) begin
            scorer_p2   <= 1'b0;
            P1_Score_o  <= P1_Score_o + SCORE_WIDTH'(1);
            Point_P1_o  <= 1'b1;
            Serve_Dir_o <= 1'b1;
          end
        end
        POINT: begin
          if (match_won) begin
            Winner_o     <= scorer_p2;
            Match_Over_o <= 1'b1;
            hold_cnt     <= HOLD_LOAD;
          end else begin
            serve_cnt <= SERVE_LOAD;
          end
        end
        MATCH_OVER: begin
          if (hold_cnt == '0)    Match_Over_o <= 1'b0;
          else if (Frame_Tick_i) hold_cnt <= hold_cnt - HOLD_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign State_o       = state;
  assign Game_Active_o = (state == RUNNING);
  assign Ball_Reset_o  = (state != RUNNING);

endmodule
